// File: rtl/prover_round_seq.sv
// Round sequencer for one sumcheck instance: launches the prover layer, captures each
// round's coefficient set on a layer_ready rising edge, emits it, then takes tau and advances.
`ifndef F_NBITS
`define F_NBITS 16
`endif

module prover_round_seq #(
   parameter int nCopyBits = 3,
   parameter int nInBits   = 3
) (
   input  logic                                                    clk,
   input  logic                                                    rstb,
   input  logic                                                    start,
   input  logic                                                    abort,
   input  logic                                                    layer_ready,
   input  logic                                                    layer_cubic,
   input  logic [((nInBits > 3 ? nInBits : 3) + 1)*`F_NBITS-1:0]   layer_coeff,
   output logic                                                    layer_en,
   output logic                                                    layer_restart,
   output logic [`F_NBITS-1:0]                                     layer_tau,
   output logic                                                    coeff_valid,
   input  logic                                                    coeff_ready,
   output logic [((nInBits > 3 ? nInBits : 3) + 1)*`F_NBITS-1:0]   coeff_out,
   output logic                                                    coeff_cubic,
   output logic                                                    coeff_last,
   output logic [$clog2(nCopyBits + 2*nInBits + 1)-1:0]            round_idx,
   input  logic                                                    tau_valid,
   input  logic [`F_NBITS-1:0]                                     tau,
   output logic                                                    tau_ready,
   output logic                                                    busy,
   output logic                                                    done,
   output logic                                                    err
);

   localparam int nRounds   = nCopyBits + 2*nInBits;
   localparam int lastCoeff = (nInBits > 3) ? nInBits : 3;
   localparam int nRndBits  = $clog2(nRounds + 1);

   typedef enum logic [2:0] {IDLE, KICK, WAIT, EMIT, TAU, ADV} state_t;

   state_t state, state_nxt;
   logic   ready_dly;
   logic   ready_rise;

   assign ready_rise    = layer_ready && !ready_dly;
   assign layer_en      = (state == KICK) || (state == ADV);
   assign layer_restart = (state == KICK);
   assign coeff_valid   = (state == EMIT);
   assign tau_ready     = (state == TAU);
   assign busy          = (state != IDLE);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)       state_nxt = KICK;
         KICK:                     state_nxt = WAIT;
         WAIT:    if (ready_rise)  state_nxt = EMIT;
         EMIT:    if (coeff_ready) state_nxt = coeff_last ? IDLE : TAU;
         TAU:     if (tau_valid)   state_nxt = ADV;
         ADV:                      state_nxt = WAIT;
         default:                  state_nxt = IDLE;
      endcase
      // abort outranks every handshake taken in the same cycle
      if (abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ready_dly   <= 1'b1;
         layer_tau   <= '0;
         coeff_out   <= '0;
         coeff_cubic <= 1'b0;
         coeff_last  <= 1'b0;
         round_idx   <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         ready_dly <= layer_ready;
         done      <= !abort && (state == EMIT) && coeff_ready && coeff_last;

         if (!abort && (state == IDLE) && start) begin
            round_idx <= '0;
            err       <= 1'b0;
         end else if (ready_rise && ((state == EMIT) || (state == TAU) || (state == ADV))) begin
            // layer completed a round we were not waiting for: flag it and drop the edge
            err <= 1'b1;
         end

         if (!abort && (state == WAIT) && ready_rise) begin
            coeff_out   <= layer_coeff;
            coeff_cubic <= layer_cubic;
            coeff_last  <= (round_idx == nRndBits'(nRounds));
         end

         if (!abort && (state == TAU) && tau_valid) begin
            layer_tau <= tau;
            round_idx <= round_idx + nRndBits'(1);
         end
      end
   end

endmodule

// File: tb/tb_prover_round_seq.sv
// Randomized bench for prover_round_seq: an inline layer model produces random coefficient
// sets with random latency, and every emitted set, tau and pulse is checked against it.
`ifndef F_NBITS
`define F_NBITS 16
`endif

module tb_prover_round_seq;

   localparam int NC = 3;
   localparam int NI = 3;
   localparam int NR = NC + 2*NI;
   localparam int LC = (NI > 3) ? NI : 3;
   localparam int FW = `F_NBITS;
   localparam int CW = (LC + 1)*FW;
   localparam int RB = $clog2(NR + 1);

   logic          clk = 1'b0;
   logic          rstb = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          layer_ready = 1'b1;
   logic          layer_cubic = 1'b0;
   logic [CW-1:0] layer_coeff = '0;
   logic          layer_en;
   logic          layer_restart;
   logic [FW-1:0] layer_tau;
   logic          coeff_valid;
   logic          coeff_ready = 1'b0;
   logic [CW-1:0] coeff_out;
   logic          coeff_cubic;
   logic          coeff_last;
   logic [RB-1:0] round_idx;
   logic          tau_valid = 1'b0;
   logic [FW-1:0] tau = '0;
   logic          tau_ready;
   logic          busy;
   logic          done;
   logic          err;

   int n_assert = 0;
   int n_fail   = 0;
   int en_cnt   = 0;
   int rs_cnt   = 0;
   int done_cnt = 0;
   int set_cnt  = 0;
   logic [FW-1:0] model_tau = '0;

   prover_round_seq #(.nCopyBits(NC), .nInBits(NI)) dut (
      .clk(clk), .rstb(rstb), .start(start), .abort(abort),
      .layer_ready(layer_ready), .layer_cubic(layer_cubic), .layer_coeff(layer_coeff),
      .layer_en(layer_en), .layer_restart(layer_restart), .layer_tau(layer_tau),
      .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_out(coeff_out),
      .coeff_cubic(coeff_cubic), .coeff_last(coeff_last), .round_idx(round_idx),
      .tau_valid(tau_valid), .tau(tau), .tau_ready(tau_ready),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (layer_en)                   en_cnt   <= en_cnt + 1;
      if (layer_restart)              rs_cnt   <= rs_cnt + 1;
      if (done)                       done_cnt <= done_cnt + 1;
      if (coeff_valid && coeff_ready) set_cnt  <= set_cnt + 1;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_en"},      CW'(layer_en), CW'(0));
      chk({tag, "_restart"}, CW'(layer_restart), CW'(0));
      chk({tag, "_tau"},     CW'(layer_tau), CW'(0));
      chk({tag, "_valid"},   CW'(coeff_valid), CW'(0));
      chk({tag, "_coeff"},   coeff_out, CW'(0));
      chk({tag, "_cubic"},   CW'(coeff_cubic), CW'(0));
      chk({tag, "_last"},    CW'(coeff_last), CW'(0));
      chk({tag, "_round"},   CW'(round_idx), CW'(0));
      chk({tag, "_tready"},  CW'(tau_ready), CW'(0));
      chk({tag, "_busy"},    CW'(busy), CW'(0));
      chk({tag, "_done"},    CW'(done), CW'(0));
      chk({tag, "_err"},     CW'(err), CW'(0));
   endtask

   // One sumcheck. Round arguments of -1 disable the corresponding disturbance.
   task automatic run(input int stall_r, input int spur_r, input int mid_start_r,
                      input int abort_r, input int first_hold, input bit seq_tau);
      int            e0, r0, d0, s0;
      logic [CW-1:0] exp_coeff;
      logic          exp_cubic;
      logic [FW-1:0] tau_v;
      bit            got;
      e0 = en_cnt; r0 = rs_cnt; d0 = done_cnt; s0 = set_cnt;

      start = 1'b1;
      step();
      start = 1'b0;
      chk("kick_restart", CW'(layer_restart), CW'(1));
      chk("kick_en",      CW'(layer_en), CW'(1));
      chk("kick_err",     CW'(err), CW'(0));
      chk("kick_busy",    CW'(busy), CW'(1));

      for (int r = 0; r <= NR; r++) begin
         // layer_ready is still high from before: no edge, no capture
         repeat ((r == 0) ? first_hold : int'($urandom_range(0, 2))) begin
            step();
            chk("no_capture_high", CW'(coeff_valid), CW'(0));
         end
         layer_ready = 1'b0;
         repeat ($urandom_range(1, 3)) begin
            step();
            chk("no_capture_low", CW'(coeff_valid), CW'(0));
         end
         for (int k = 0; k <= LC; k++) exp_coeff[k*FW +: FW] = FW'($urandom);
         exp_cubic   = 1'($urandom_range(0, 1));
         layer_coeff = exp_coeff;
         layer_cubic = exp_cubic;
         layer_ready = 1'b1;
         coeff_ready = (r != stall_r);

         got = 1'b0;
         for (int w = 0; w < 10 && !got; w++) begin
            step();
            got = coeff_valid;
         end
         chk("coeff_valid_timeout", CW'(got), CW'(1));
         if (!got) return;
         layer_coeff = ~exp_coeff;
         layer_cubic = ~exp_cubic;
         chk("coeff_out",   coeff_out, exp_coeff);
         chk("coeff_cubic", CW'(coeff_cubic), CW'(exp_cubic));
         chk("round_idx",   CW'(round_idx), CW'(r));
         chk("coeff_last",  CW'(coeff_last), CW'(r == NR));
         chk("emit_tready", CW'(tau_ready), CW'(0));

         if (r == stall_r) begin
            repeat (5) begin
               step();
               chk("stall_valid",  CW'(coeff_valid), CW'(1));
               chk("stall_coeff",  coeff_out, exp_coeff);
               chk("stall_round",  CW'(round_idx), CW'(r));
               chk("stall_tready", CW'(tau_ready), CW'(0));
            end
            coeff_ready = 1'b1;
         end
         step();
         coeff_ready = 1'b0;

         if (r == NR) begin
            chk("final_done",  CW'(done), CW'(1));
            chk("final_busy",  CW'(busy), CW'(0));
            chk("final_valid", CW'(coeff_valid), CW'(0));
            break;
         end
         chk("tau_ready", CW'(tau_ready), CW'(1));
         chk("mid_done",  CW'(done), CW'(0));

         if (r == spur_r) begin
            layer_ready = 1'b0;
            step();
            layer_ready = 1'b1;
            step();
            chk("spur_err",    CW'(err), CW'(1));
            chk("spur_tready", CW'(tau_ready), CW'(1));
            chk("spur_round",  CW'(round_idx), CW'(r));
         end

         if (r == mid_start_r) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk("midstart_restart", CW'(layer_restart), CW'(0));
            chk("midstart_tready",  CW'(tau_ready), CW'(1));
            chk("midstart_round",   CW'(round_idx), CW'(r));
         end

         tau_v     = seq_tau ? FW'(r + 1) : FW'($urandom);
         tau       = tau_v;
         tau_valid = 1'b1;
         if (r == abort_r) begin
            abort = 1'b1;
            step();
            abort     = 1'b0;
            tau_valid = 1'b0;
            chk("abort_busy",   CW'(busy), CW'(0));
            chk("abort_en",     CW'(layer_en), CW'(0));
            chk("abort_tready", CW'(tau_ready), CW'(0));
            chk("abort_tau",    CW'(layer_tau), CW'(model_tau));
            chk("abort_round",  CW'(round_idx), CW'(r));
            step();
            chk("abort_done", CW'(done), CW'(0));
            chk("abort_idle", CW'(busy), CW'(0));
            return;
         end
         step();
         tau_valid = 1'b0;
         model_tau = tau_v;
         chk("adv_en",      CW'(layer_en), CW'(1));
         chk("adv_restart", CW'(layer_restart), CW'(0));
         chk("adv_tau",     CW'(layer_tau), CW'(model_tau));
         chk("adv_round",   CW'(round_idx), CW'(r + 1));
      end

      step();
      chk("done_pulse_once", CW'(done), CW'(0));
      chk("cnt_layer_en",    CW'(en_cnt - e0), CW'(NR + 1));
      chk("cnt_restart",     CW'(rs_cnt - r0), CW'(1));
      chk("cnt_done",        CW'(done_cnt - d0), CW'(1));
      chk("cnt_sets",        CW'(set_cnt - s0), CW'(NR + 1));
      chk("end_err",         CW'(err), CW'(spur_r >= 0));
   endtask

   initial begin
      // reset with layer_ready held high
      repeat (3) step();
      chk_idle_outputs("rst");
      rstb = 1'b1;
      step();
      chk_idle_outputs("post_rst");

      run(-1, -1, -1, -1, 4, 1'b1);  // plain run, taus 1..NR
      run( 4, -1, -1, -1, 1, 1'b0);  // backpressure at round 4
      run(-1,  5, -1, -1, 0, 1'b0);  // spurious edge while in TAU
      run(-1, -1, -1,  6, 2, 1'b0);  // abort together with tau_valid at round 6
      run(-1, -1,  2, -1, 0, 1'b0);  // start pulsed mid-run
      repeat (3) run(int'($urandom_range(0, NR)), -1, -1, -1, int'($urandom_range(0, 3)), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
